// File: rtl/reg3_arbiter.sv
// Round-robin arbiter and one-shot write sequencer for a shared 3-bit enable register.
// Each transaction is one IDLE->WR->ACK pass; outputs decode from state, owner and held data only.
module reg3_arbiter (
  input  logic       eck,
  input  logic       er,
  input  logic [2:0] ereq,
  input  logic [2:0] ed0,
  input  logic [2:0] ed1,
  input  logic [2:0] ed2,
  output logic [2:0] sgnt,
  output logic [2:0] sack,
  output logic [2:0] sed,
  output logic       seena,
  output logic       sbusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] w_q, w_d;
  logic [2:0] hold_q, hold_d;

  logic [2:0][2:0] ed_all;
  logic [1:0]      win, idx;
  logic            found;
  logic [2:0]      own_oh;

  assign ed_all = {ed2, ed1, ed0};

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // First requester at or after ptr, wrapping modulo 3.
  always_comb begin
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!found && ereq[idx]) begin
        win   = idx;
        found = 1'b1;
      end
      idx = inc3(idx);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          w_d     = win;
          hold_d  = ed_all[win];
          ptr_d   = inc3(win);
          state_d = WR;
        end
      end
      WR:      state_d = ACK;
      ACK:     if (!ereq[w_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge eck or negedge er) begin
    if (!er) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      w_q     <= 2'd0;
      hold_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      hold_q  <= hold_d;
    end
  end

  // Reset forces IDLE asynchronously, so seena and grants drop without waiting for an edge.
  always_comb begin
    own_oh = 3'b001 << w_q;
    sgnt   = (state_q != IDLE) ? own_oh : 3'b000;
    sack   = (state_q == ACK)  ? own_oh : 3'b000;
    sed    = hold_q;
    seena  = (state_q == WR);
    sbusy  = (state_q != IDLE);
  end

endmodule

// File: doc/reg3_arbiter.md
# reg3_arbiter

Round-robin arbiter and write sequencer for a shared 3-bit enable register (three DFFRSE-based bits with data, clock and enable inputs). Three requesters compete for write access. The block selects a winner and latches that requester's 3-bit data. It then drives the register's data and enable inputs for exactly one clock and completes a 4-phase req/ack handshake with the winner. It sits between the requesting units and the register instance, and is the only driver of that register's data and enable pins.

## Interface
Parameters: none. Widths are fixed at 3 requesters × 3 data bits.

- eck  in  1  clock; all state changes on rising edge
- er  in  1  asynchronous, active-low reset
- ereq  in  3  request lines, bit i = requester i
- ed0  in  3  data from requester 0
- ed1  in  3  data from requester 1
- ed2  in  3  data from requester 2
- sgnt  out  3  one-hot grant, current owner; 000 when idle
- sack  out  3  one-hot acknowledge to owner
- sed  out  3  data to register d inputs
- seena  out  1  register enable; high exactly one cycle per transaction
- sbusy  out  1  high in any state other than IDLE

## Operation
- State machine has three states, 2-bit encoded:
  - IDLE
  - WR (write cycle)
  - ACK (handshake completion)
- Round-robin pointer ptr ∈ {0,1,2}.
  - Winner = first i with ereq[i]=1, searching ptr, ptr+1, ptr+2 modulo 3.
- IDLE:
  - If ereq≠000: latch winner index w, latch data edw into an internal 3-bit holding register, set ptr←(w+1) mod 3 (2 wraps to 0), go to WR.
  - Otherwise stay in IDLE.
- WR:
  - sgnt[w]=1, sed=held data, seena=1.
  - Unconditionally go to ACK on the next edge.
- ACK:
  - sgnt[w]=1, sack[w]=1, seena=0, sed=held data.
  - Stay while ereq[w]=1.
  - When ereq[w]=0, go to IDLE.
- Outputs are Moore-type: decoded from state, w and the holding register only. No combinational path from ereq or edN to any output.
- Requests from non-owners are ignored while sbusy=1. They stay pending and are evaluated in the next IDLE cycle.
- Requester data is sampled only on the IDLE→WR edge. Later changes to edN do not affect the write.

## Timing
- Reset (er=0), asynchronous:
  - State=IDLE, ptr=0, w=0, holding register=000.
  - sgnt=000, sack=000, sed=000, seena=0, sbusy=0.
  - Reset asserted during WR removes seena immediately, so the register sees no enable at the next edge.
- Latency:
  - Edge k samples a request in IDLE.
  - seena is high during cycle k+1 and the register captures at edge k+2.
  - sack rises at edge k+2, in the same cycle the register output shows the new value.
- Minimum transaction length is 3 cycles: IDLE, WR, and one ACK cycle with req already low. Back-to-back grants are separated by at least one IDLE cycle.
- If the winner drops req during WR (protocol violation):
  - The write still completes.
  - ACK is entered and exits after 1 cycle, so sack pulses once.
- Simultaneous requests: exactly one grant per transaction; ordering follows ptr.
- If ereq[w] is held high forever, the block stays in ACK and the other requesters starve. This is defined behaviour and the requester's responsibility.

## Test plan
- Reset check: er=0 mid-WR with ereq=001, ed0=101. Required:
  - All outputs drop at once: seena=0, sgnt=000.
  - After er=1 with ereq=000, the block stays in IDLE with ptr=0.
- Single request: ereq=010, ed1=110. Required:
  - Next cycle: sgnt=010, seena=1, sed=110.
  - Following cycle: sack=010, seena=0.
  - Drop ereq[1]: IDLE one cycle later, sbusy=0.
- Round-robin fairness: ereq=111 held, each owner drops req after sack. Required:
  - Grant order 0,1,2,0.
  - ptr after each grant is 1,2,0,1.
- Wrap-around: with ptr=2 and ereq=011, requester 0 wins (not 1). After the grant, ptr=1.
- Data stability: ereq=100, ed2=011, ed2 changed to 111 during WR. Required: sed stays 011 for the whole transaction and the register captures 011.
- Early release: winner deasserts req during WR. Required: seena is high for exactly 1 cycle, sack is high for exactly 1 cycle, then IDLE, and a pending request is granted on the next edge.
